// File: rtl/reorder_buffer_if.sv
// Handshake bundle between dispatch/execute/commit and the reorder buffer.
// master = core side driving requests, slave = the buffer itself.
interface reorder_buffer_if #(
    parameter int TAG_W  = 4,
    parameter int PREG_W = 6
);
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_dest;
    logic [PREG_W-1:0] alloc_old_p_reg;
    logic              alloc_halt;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cmpl_valid;
    logic [TAG_W-1:0]  cmpl_tag;
    logic              flush_valid;
    logic [TAG_W-1:0]  flush_tag;
    logic              commit_valid;
    logic              commit_dest;
    logic [PREG_W-1:0] commit_addr;
    logic              halt;
    logic [TAG_W:0]    count;

    modport master (
        output alloc_valid, alloc_dest, alloc_old_p_reg, alloc_halt,
               cmpl_valid, cmpl_tag, flush_valid, flush_tag,
        input  alloc_ready, alloc_tag, commit_valid, commit_dest,
               commit_addr, halt, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, alloc_old_p_reg, alloc_halt,
               cmpl_valid, cmpl_tag, flush_valid, flush_tag,
        output alloc_ready, alloc_tag, commit_valid, commit_dest,
               commit_addr, halt, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, retires completed
// head entries one per cycle, and truncates younger entries on a mispredict.
module reorder_buffer #(
    parameter int DEPTH   = 16,
    parameter int NUM_REG = 64,
    parameter int PREG_W  = $clog2(NUM_REG),
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            n_rst,
    reorder_buffer_if.slave rob
);

    localparam logic [TAG_W:0]   FULL    = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    logic [DEPTH-1:0]  valid_q, done_q;
    logic [DEPTH-1:0]  dest_q, halt_e_q;
    logic [PREG_W-1:0] old_p_reg_q [DEPTH];
    logic [TAG_W-1:0]  head_q, tail_q;
    logic [TAG_W:0]    count_q;
    logic              halt_q;

    logic [DEPTH-1:0]  valid_d, done_d, squash;
    logic [TAG_W-1:0]  head_d, tail_d, rel;
    logic [TAG_W:0]    count_d, keep_len, retire_w, alloc_w;
    logic              halt_d, retire, ready, alloc;

    always_comb begin
        retire   = valid_q[head_q] & done_q[head_q] & ~halt_q;
        ready    = (count_q != FULL) & ~halt_q;
        alloc    = rob.alloc_valid & ready & ~rob.flush_valid;
        retire_w = {{TAG_W{1'b0}}, retire};
        alloc_w  = {{TAG_W{1'b0}}, alloc};

        // Entries kept by a flush are head..flush_tag; measuring age from the
        // head keeps this correct when the buffer is full (head == tail).
        keep_len = {1'b0, rob.flush_tag - head_q} + CNT_ONE;
        rel      = '0;
        squash   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel       = TAG_W'(i) - head_q;
            squash[i] = rob.flush_valid & ({1'b0, rel} >= keep_len);
        end

        valid_d = valid_q & ~squash;
        if (retire) valid_d[head_q] = 1'b0;
        if (alloc)  valid_d[tail_q] = 1'b1;

        done_d = done_q;
        if (rob.cmpl_valid & valid_q[rob.cmpl_tag] & ~squash[rob.cmpl_tag])
            done_d[rob.cmpl_tag] = 1'b1;
        if (alloc) done_d[tail_q] = 1'b0;

        head_d = head_q + {{(TAG_W-1){1'b0}}, retire};
        if (rob.flush_valid) begin
            tail_d  = rob.flush_tag + TAG_ONE;
            count_d = keep_len - retire_w;
        end else begin
            tail_d  = tail_q + {{(TAG_W-1){1'b0}}, alloc};
            count_d = count_q + alloc_w - retire_w;
        end

        halt_d = halt_q | (retire & halt_e_q[head_q]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            halt_q  <= halt_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            dest_q[tail_q]      <= rob.alloc_dest;
            halt_e_q[tail_q]    <= rob.alloc_halt;
            old_p_reg_q[tail_q] <= rob.alloc_old_p_reg;
        end
    end

    assign rob.alloc_ready  = ready;
    assign rob.alloc_tag    = tail_q;
    assign rob.commit_valid = retire;
    assign rob.commit_dest  = retire & dest_q[head_q];
    assign rob.commit_addr  = retire ? old_p_reg_q[head_q] : '0;
    assign rob.halt         = halt_q;
    assign rob.count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus randomized bench for reorder_buffer against a program-order
// queue model of the buffer contents.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic clk;
    logic n_rst;

    reorder_buffer_if #(.TAG_W(4), .PREG_W(6)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .NUM_REG(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .rob   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit dest;
        int addr;
        bit hlt;
        bit done;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    bit   m_halt;
    int   n_chk;
    int   n_pass;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drv(bit av, bit d, int a, bit h, bit cv, int ct, bit fv, int ft);
        bus.alloc_valid     = av;
        bus.alloc_dest      = d;
        bus.alloc_old_p_reg = 6'(a);
        bus.alloc_halt      = h;
        bus.cmpl_valid      = cv;
        bus.cmpl_tag        = 4'(ct);
        bus.flush_valid     = fv;
        bus.flush_tag       = 4'(ft);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Checks all outputs mid-cycle against the model, then advances one edge.
    task automatic step();
        int tl, k;
        bit rdy, cv, ed;
        int ea;
        @(negedge clk);
        tl  = (m_head + mq.size()) % DEPTH;
        rdy = (mq.size() < DEPTH) && !m_halt;
        cv  = 0;
        ed  = 0;
        ea  = 0;
        if (mq.size() > 0 && !m_halt && mq[0].done) begin
            cv = 1;
            ed = mq[0].dest;
            ea = mq[0].addr;
        end
        check("alloc_ready", bus.alloc_ready, rdy);
        check("alloc_tag", bus.alloc_tag, tl);
        check("commit_valid", bus.commit_valid, cv);
        check("commit_dest", bus.commit_dest, ed);
        check("commit_addr", bus.commit_addr, ea);
        check("halt", bus.halt, m_halt);
        check("count", bus.count, mq.size());
        @(posedge clk);
        if (cv) begin
            if (mq[0].hlt) m_halt = 1;
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (bus.flush_valid) begin
            k = -1;
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].tag == int'(bus.flush_tag)) k = i;
            if (k >= 0)
                while (mq.size() > k + 1) void'(mq.pop_back());
        end
        if (bus.cmpl_valid)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].tag == int'(bus.cmpl_tag)) mq[i].done = 1;
        if (bus.alloc_valid && rdy && !bus.flush_valid) begin
            ent_t e;
            e.tag  = tl;
            e.dest = bus.alloc_dest;
            e.addr = int'(bus.alloc_old_p_reg);
            e.hlt  = bus.alloc_halt;
            e.done = 0;
            mq.push_back(e);
        end
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; outputs checked before any edge.
    task automatic do_reset();
        idle();
        n_rst = 1'b0;
        #2;
        check("rst_count", bus.count, 0);
        check("rst_alloc_ready", bus.alloc_ready, 1);
        check("rst_alloc_tag", bus.alloc_tag, 0);
        check("rst_commit_valid", bus.commit_valid, 0);
        check("rst_commit_dest", bus.commit_dest, 0);
        check("rst_commit_addr", bus.commit_addr, 0);
        check("rst_halt", bus.halt, 0);
        mq.delete();
        m_head = 0;
        m_halt = 0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hcnt;
        n_chk  = 0;
        n_pass = 0;
        hcnt   = 0;
        n_rst  = 1'b1;
        idle();
        #1;
        do_reset();

        // Idle: a completion to an unallocated tag is ignored.
        drv(0, 0, 0, 0, 1, 3, 0, 0);
        step();
        idle();
        step();

        // Out-of-order completion: tags 0..3, complete 2, 3, 1, then 0.
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 40 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(0, 0, 0, 0, 1, 2, 0, 0); step();
        check("ooo_wait0", bus.commit_valid, 0);
        drv(0, 0, 0, 0, 1, 3, 0, 0); step();
        check("ooo_wait1", bus.commit_valid, 0);
        drv(0, 0, 0, 0, 1, 1, 0, 0); step();
        check("ooo_wait2", bus.commit_valid, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0); step();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("ooo_commit_valid", bus.commit_valid, 1);
            check("ooo_commit_addr", bus.commit_addr, 40 + i);
            step();
        end
        check("ooo_empty", bus.count, 0);

        // Fill and drain from a clean reset.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drv(1, 1, 10 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(1, 1, 63, 0, 0, 0, 0, 0);
        check("full_ready", bus.alloc_ready, 0);
        check("full_count", bus.count, DEPTH);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            drv(0, 0, 0, 0, 1, 15 - i, 0, 0);
            if (i > 0) check("drain_hold", bus.commit_valid, 0);
            step();
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", bus.commit_valid, 1);
            check("drain_addr", bus.commit_addr, 10 + i);
            step();
        end
        check("drain_empty", bus.count, 0);

        // Move head to 14, then wrap with tail at 2 and alloc during retire.
        for (int i = 0; i < 14; i++) begin
            drv(1, 0, i, 0, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 14; i++) begin
            drv(0, 0, 0, 0, 1, i, 0, 0);
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 20 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(0, 0, 0, 0, 1, 14, 0, 0);
        step();
        drv(1, 1, 33, 0, 0, 0, 0, 0);
        check("wrap_tag_before", bus.alloc_tag, 2);
        check("wrap_count_before", bus.count, 4);
        check("wrap_commit", bus.commit_valid, 1);
        step();
        idle();
        check("wrap_count_after", bus.count, 4);
        check("wrap_tag_after", bus.alloc_tag, 3);

        // Flush at tag 3 with a colliding alloc and completion to tag 5.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1, i % 2, 30 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(1, 1, 50, 0, 1, 5, 1, 3);
        check("flush_ready_in", bus.alloc_ready, 1);
        step();
        idle();
        check("flush_count", bus.count, 4);
        check("flush_tail", bus.alloc_tag, 4);
        drv(0, 0, 0, 0, 1, 5, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 1, i, 0, 0);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        check("flush_drained", bus.count, 0);
        check("flush_no_commit", bus.commit_valid, 0);

        // Halt at tag 2; tag 3 completes but must never retire.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 5 + i, (i == 2), 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 1, i, 0, 0);
            step();
        end
        drv(1, 1, 9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        check("halt_set", bus.halt, 1);
        check("halt_ready", bus.alloc_ready, 0);
        check("halt_no_commit", bus.commit_valid, 0);
        check("halt_count", bus.count, 1);
        do_reset();

        // Randomized traffic against the queue model.
        for (int c = 0; c < 2500; c++) begin
            bit av, d, h, cv, fv;
            int a, ct, ft, lo;
            av = ($urandom_range(0, 9) < 6);
            d  = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 63);
            h  = ($urandom_range(0, 63) == 0);
            cv = ($urandom_range(0, 9) < 7);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                ct = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                ct = $urandom_range(0, DEPTH - 1);
            fv = 0;
            ft = 0;
            if (mq.size() > 0 && $urandom_range(0, 19) == 0) begin
                lo = (mq[0].done && !m_halt) ? 1 : 0;
                if (lo < mq.size()) begin
                    fv = 1;
                    ft = mq[$urandom_range(lo, mq.size() - 1)].tag;
                end
            end
            drv(av, d, a, h, cv, ct, fv, ft);
            step();
            if (m_halt) hcnt++;
            if (hcnt > 6) begin
                hcnt = 0;
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core, sitting between rename/dispatch and `commit_unit`. Each renamed instruction is allocated an entry in program order and marked done when execution writes back. Completed entries retire from the head, one per cycle, releasing the superseded physical register to `free_reg_list`. A branch mispredict truncates all entries younger than the branch.

## Interface
- `DEPTH`, 16, number of entries; must be a power of two and at least 4.
- `PREG_W`, `$clog2(`NUM_REG)`, physical register address width.
- `TAG_W`, `$clog2(DEPTH)`, entry index width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `alloc_valid`  in  1  dispatch presents one instruction this cycle.
- `alloc_ready`  out  1  an entry is free; allocation occurs when `alloc_valid & alloc_ready`.
- `alloc_dest`  in  1  the instruction writes a register.
- `alloc_old_p_reg`  in  PREG_W  previous mapping of the destination, freed at retire.
- `alloc_halt`  in  1  the instruction is a halt.
- `alloc_tag`  out  TAG_W  index given to the allocating instruction; equals the tail pointer.
- `cmpl_valid`  in  1  execution writeback for one entry.
- `cmpl_tag`  in  TAG_W  entry being completed.
- `flush_valid`  in  1  mispredict; discard every entry younger than `flush_tag`.
- `flush_tag`  in  TAG_W  tag of the mispredicted branch; this entry is kept.
- `commit_valid`  out  1  head entry retires this cycle; drives `reg_write` in `commit_unit`.
- `commit_dest`  out  1  the retiring entry has a destination.
- `commit_addr`  out  PREG_W  `old_p_reg` of the retiring entry.
- `halt`  out  1  sticky; set when a halt entry retires.
- `count`  out  TAG_W+1  number of occupied entries.

## Operation
- Per-entry state: `valid`, `done`, `dest`, `old_p_reg`, `halt`. Head and tail pointers are TAG_W bits and wrap modulo DEPTH. `count` is a separate register, so full and empty are unambiguous.
- Allocate: write the entry at `tail` with `done=0`, then `tail+1` and `count+1`. `alloc_ready = (count != DEPTH) & ~halt`.
- Complete: set `done` for `cmpl_tag` only if that entry is valid. A completion to an invalid entry is ignored.
- Retire: `commit_valid = valid[head] & done[head] & ~halt`. When it is asserted, clear `valid[head]`, then `head+1` and `count-1`. `commit_dest` and `commit_addr` come combinationally from the head entry. Both are 0 when `commit_valid=0`.
- Halt: when a retiring entry has `halt=1`, set `halt` at that edge. After that, no further retire or allocate occurs until reset.
- Flush: the entries from `flush_tag+1` through `tail-1` are invalidated. The next `tail` is `flush_tag+1`. The next `count` is `((flush_tag - head) mod DEPTH) + 1`, minus 1 if the head retires in the same cycle.
- Simultaneous events in one cycle:
  - Flush wins over alloc; the alloc is dropped, even though `alloc_ready` may have been high.
  - A completion aimed at a squashed entry is dropped.
  - Retire proceeds normally during a flush. `flush_tag` is never the head while the head is retiring, because a branch cannot retire before it resolves.
  - Alloc and retire in the same cycle leave `count` unchanged.
  - `alloc_ready` does not count a same-cycle retire, so a full buffer refuses allocation that cycle.
- Freeing of the physical registers of squashed entries is out of scope; it is handled by the translation table snapshot logic.

## Timing
- Reset (asynchronous, `n_rst=0`) sets:
  - head=0, tail=0, count=0, all valid=0, halt=0.
  - Outputs: `alloc_ready=1`, `alloc_tag=0`, `commit_valid=0`, `commit_dest=0`, `commit_addr=0`, `count=0`.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latencies:
  - Allocate to visible: 1 cycle.
  - Complete to retire: at least 1 cycle. `done` is registered and retire reads registered state only, so a completion at edge N allows retire in cycle N+1.
  - Alloc to earliest retire: 2 cycles.
- Retire rate is at most one entry per cycle. `commit_*` signals are valid for the whole cycle and are sampled by `commit_unit` and `free_reg_list` at the next edge.

## Test plan
- Reset then idle: `count=0`, `alloc_ready=1`, `commit_valid=0`, `halt=0`; a completion to tag 3 is ignored, and no `done` bit is set.
- Fill and drain:
  - Allocate 16 entries with old_p_reg = 10..25; the 17th alloc sees `alloc_ready=0`.
  - Complete tags 15..0 in reverse order.
  - Commits appear one per cycle, in order, with `commit_addr` = 10..25, starting the cycle after tag 0 completes.
- Out-of-order completion: allocate tags 0..3 and complete 2, 3, 1. No commit occurs until tag 0 completes; then tags 0, 1, 2, 3 retire on four consecutive cycles.
- Wrap plus simultaneous alloc/retire: with head=14 and tail=2 (count=4), retire tag 14 while allocating. `count` stays at 4, tail becomes 3, and `alloc_tag` wraps correctly.
- Flush: with head=0 and tail=8, apply flush_tag=3 together with `alloc_valid` and `cmpl_tag=5`. Next cycle: tail=4, count=4, tags 4..7 invalid, no alloc, and tag 5 is not done.
- Halt: allocate a halt at tag 2 and complete tags 0..2. After tag 2 retires, `halt=1` and `alloc_ready=0`, and tag 3 never commits even if it is complete. Asserting `n_rst=0` clears `halt` asynchronously.
